// File: rtl/eth_txstate_ctrl_pkg.sv
// Shared types and defaults for the Tx MAC state controller.
// The half-duplex datapath is present only when ETH_TX_HALF_DUPLEX_EN is defined.
package eth_txstate_ctrl_pkg;

  localparam int IPG_W_DEF = 7;

  typedef enum logic [3:0] {
    TX_IDLE     = 4'd0,
    TX_DEFER    = 4'd1,
    TX_IPG      = 4'd2,
    TX_PREAMBLE = 4'd3,
    TX_DATA0    = 4'd4,
    TX_DATA1    = 4'd5,
    TX_PAD      = 4'd6,
    TX_FCS      = 4'd7,
    TX_JAM      = 4'd8,
    TX_BACKOFF  = 4'd9
  } txState_t;

endpackage

// File: rtl/eth_txstate_ctrl_if.sv
// Bundle between the Tx state controller, the host side and the nibble counter stage.
// Half-duplex members are always present; they are ignored unless ETH_TX_HALF_DUPLEX_EN is defined.
interface eth_txstate_ctrl_if
  import eth_txstate_ctrl_pkg::*;
  #(parameter int IPG_W = IPG_W_DEF);

  logic             TxStartFrm, TxEndFrm, CarrierSense, Collision, FullD, Pad, CrcEn;
  logic [IPG_W-1:0] IPGT, IPGR1, IPGR2;
  logic [15:0]      NibCnt;
  logic             NibCntEq7, NibCntEq15, NibbleMinFl, MaxFrame, ExcessiveDefer;
  logic             RetryMax, RandomEqByteCnt;

  logic             StateIdle, StateDefer, StateIPG, StatePreamble, StatePAD, StateFCS;
  logic             StateJam, StateBackOff, StateSFD;
  logic [1:0]       StateData;
  logic             StartDefer, StartIPG, StartFCS, StartJam, StartBackoff, TxAbort;
  txState_t         TxStateDbg;

  // Handshake: TxStartFrm is a level request with no ready; it is taken only in IDLE
  // (frame wins over carrier), and the host sees acceptance as StatePreamble rising.
  modport slave (
    input  TxStartFrm, TxEndFrm, CarrierSense, Collision, FullD, Pad, CrcEn,
           IPGT, IPGR1, IPGR2, NibCnt, NibCntEq7, NibCntEq15, NibbleMinFl,
           MaxFrame, ExcessiveDefer, RetryMax, RandomEqByteCnt,
    output StateIdle, StateDefer, StateIPG, StatePreamble, StatePAD, StateFCS,
           StateJam, StateBackOff, StateSFD, StateData,
           StartDefer, StartIPG, StartFCS, StartJam, StartBackoff, TxAbort, TxStateDbg
  );

  modport master (
    output TxStartFrm, TxEndFrm, CarrierSense, Collision, FullD, Pad, CrcEn,
           IPGT, IPGR1, IPGR2, NibCnt, NibCntEq7, NibCntEq15, NibbleMinFl,
           MaxFrame, ExcessiveDefer, RetryMax, RandomEqByteCnt,
    input  StateIdle, StateDefer, StateIPG, StatePreamble, StatePAD, StateFCS,
           StateJam, StateBackOff, StateSFD, StateData,
           StartDefer, StartIPG, StartFCS, StartJam, StartBackoff, TxAbort, TxStateDbg
  );

endinterface

// File: rtl/eth_txstate_ctrl_ipg.sv
// Inter-packet-gap compare: decides when IPG is complete and when carrier sends us back to DEFER.
module eth_txstate_ctrl_ipg
  import eth_txstate_ctrl_pkg::*;
  #(parameter int IPG_W = IPG_W_DEF)
  (
    input  logic [IPG_W-1:0] NibCntLow,
    input  logic [IPG_W-1:0] IPGT,
    input  logic [IPG_W-1:0] IPGR1,
    input  logic [IPG_W-1:0] IPGR2,
    input  logic             CarrierSense,
    input  logic             HalfDup,
    input  logic             B2b,
    output logic             IpgDone,
    output logic             IpgToDefer
  );

  logic useIpgt;

  // Back-to-back or full-duplex gaps use the single IPGT; otherwise the two-part rule applies.
  assign useIpgt    = ~HalfDup | B2b;
  assign IpgDone    = useIpgt ? (NibCntLow >= IPGT) : (NibCntLow >= IPGR2);
  assign IpgToDefer = ~useIpgt & CarrierSense & (NibCntLow < IPGR1);

endmodule

// File: rtl/eth_txstate_ctrl.sv
// Tx MAC state machine: one-hot state and Start* strobes for the nibble counter stage.
// Half-duplex (carrier/collision/jam/backoff) logic is built only with ETH_TX_HALF_DUPLEX_EN.
module eth_txstate_ctrl
  import eth_txstate_ctrl_pkg::*;
  #(parameter int IPG_W = IPG_W_DEF)
  (
    input logic MTxClk,
    input logic Reset_n,
    eth_txstate_ctrl_if.slave bus
  );

  txState_t state, nextState;
  logic     abortNext, txAbortQ, b2b;
  logic     halfDup, carrierSense, collision, retryMax, backoffDone;
  logic     ipgDone, ipgToDefer, sending, unusedBits;

`ifdef ETH_TX_HALF_DUPLEX_EN
  assign halfDup      = ~bus.FullD;
  assign carrierSense = bus.CarrierSense & halfDup;
  assign collision    = bus.Collision & halfDup;
  assign retryMax     = bus.RetryMax;
  assign backoffDone  = bus.RandomEqByteCnt;
  assign unusedBits   = ^bus.NibCnt[15:IPG_W];
`else
  assign halfDup      = 1'b0;
  assign carrierSense = 1'b0;
  assign collision    = 1'b0;
  assign retryMax     = 1'b0;
  assign backoffDone  = 1'b0;
  assign unusedBits   = ^{bus.NibCnt[15:IPG_W], bus.FullD, bus.CarrierSense, bus.Collision,
                          bus.RetryMax, bus.RandomEqByteCnt};
`endif

  eth_txstate_ctrl_ipg #(.IPG_W(IPG_W)) u_ipg (
    .NibCntLow    (bus.NibCnt[IPG_W-1:0]),
    .IPGT         (bus.IPGT),
    .IPGR1        (bus.IPGR1),
    .IPGR2        (bus.IPGR2),
    .CarrierSense (carrierSense),
    .HalfDup      (halfDup),
    .B2b          (b2b),
    .IpgDone      (ipgDone),
    .IpgToDefer   (ipgToDefer)
  );

  assign sending = (state == TX_PREAMBLE) | (state == TX_DATA0) | (state == TX_DATA1) |
                   (state == TX_PAD) | (state == TX_FCS);

  always_comb begin
    nextState = state;
    abortNext = 1'b0;
    if (!Reset_n) begin
      nextState = TX_DEFER;
    end else if (collision & sending) begin
      nextState = TX_JAM;
    end else begin
      case (state)
        TX_DEFER:
          if (bus.ExcessiveDefer & bus.TxStartFrm) abortNext = 1'b1;
          else if (~carrierSense)                  nextState = TX_IPG;
        TX_IPG:
          if (ipgToDefer)   nextState = TX_DEFER;
          else if (ipgDone) nextState = TX_IDLE;
        TX_IDLE:
          if (bus.TxStartFrm) nextState = TX_PREAMBLE;
          else if (carrierSense) nextState = TX_DEFER;
        TX_PREAMBLE:
          if (bus.NibCntEq15) nextState = TX_DATA0;
        TX_DATA0:
          nextState = TX_DATA1;
        TX_DATA1:
          if (~bus.TxEndFrm & ~bus.MaxFrame)      nextState = TX_DATA0;
          else if (bus.Pad & ~bus.NibbleMinFl)    nextState = TX_PAD;
          else                                    nextState = bus.CrcEn ? TX_FCS : TX_DEFER;
        TX_PAD:
          if (bus.NibbleMinFl) nextState = bus.CrcEn ? TX_FCS : TX_DEFER;
        TX_FCS:
          if (bus.NibCntEq7) nextState = TX_DEFER;
        TX_JAM:
          if (bus.NibCntEq7) begin
            nextState = retryMax ? TX_DEFER : TX_BACKOFF;
            abortNext = retryMax;
          end
        TX_BACKOFF:
          if (backoffDone) nextState = TX_DEFER;
        default:
          nextState = TX_DEFER;
      endcase
    end
  end

  // b2b remembers that a frame went out since the last idle/backoff, selecting IPGT for the gap.
  always_ff @(posedge MTxClk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= TX_DEFER;
      txAbortQ <= 1'b0;
      b2b      <= 1'b0;
    end else begin
      state    <= nextState;
      txAbortQ <= abortNext;
      if (state == TX_PREAMBLE)                            b2b <= 1'b1;
      else if ((state == TX_IDLE) | (state == TX_BACKOFF)) b2b <= 1'b0;
    end
  end

  assign bus.StateIdle     = (state == TX_IDLE);
  assign bus.StateDefer    = (state == TX_DEFER);
  assign bus.StateIPG      = (state == TX_IPG);
  assign bus.StatePreamble = (state == TX_PREAMBLE);
  assign bus.StateData     = {state == TX_DATA1, state == TX_DATA0};
  assign bus.StatePAD      = (state == TX_PAD);
  assign bus.StateFCS      = (state == TX_FCS);
  assign bus.StateSFD      = (state == TX_PREAMBLE) & bus.NibCntEq15;
  assign bus.StartDefer    = (nextState == TX_DEFER) & (state != TX_DEFER);
  assign bus.StartIPG      = (nextState == TX_IPG)   & (state != TX_IPG);
  assign bus.StartFCS      = (nextState == TX_FCS)   & (state != TX_FCS);
  assign bus.TxAbort       = txAbortQ;
  assign bus.TxStateDbg    = state;

`ifdef ETH_TX_HALF_DUPLEX_EN
  assign bus.StateJam      = (state == TX_JAM);
  assign bus.StateBackOff  = (state == TX_BACKOFF);
  assign bus.StartJam      = (nextState == TX_JAM)     & (state != TX_JAM);
  assign bus.StartBackoff  = (nextState == TX_BACKOFF) & (state != TX_BACKOFF);
`else
  assign bus.StateJam      = 1'b0;
  assign bus.StateBackOff  = 1'b0;
  assign bus.StartJam      = 1'b0;
  assign bus.StartBackoff  = 1'b0;
`endif

endmodule

// File: tb/tb_eth_txstate_ctrl.sv
// Randomized bench for eth_txstate_ctrl: a name-based state model feeds an expected queue,
// a monitor compares every output each cycle. Follows ETH_TX_HALF_DUPLEX_EN like the RTL.
module tb_eth_txstate_ctrl;

  localparam int IPG_W = 7;
  localparam int W     = 17;
  localparam int N_CYC = 4000;

  logic MTxClk  = 1'b0;
  logic Reset_n = 1'b0;

  eth_txstate_ctrl_if #(.IPG_W(IPG_W)) bus ();

  eth_txstate_ctrl #(.IPG_W(IPG_W)) dut (
    .MTxClk  (MTxClk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 MTxClk = ~MTxClk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  int           mon_cyc = 0;

  string mState = "defer";
  bit    mB2b = 1'b0;
  bit    mAbortReg = 1'b0;

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic bit half_dup();
`ifdef ETH_TX_HALF_DUPLEX_EN
    return !bus.FullD;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit sending(input string s);
    return s == "pre" || s == "d0" || s == "d1" || s == "pad" || s == "fcs";
  endfunction

  function automatic string frame_tail();
    if (bus.Pad && !bus.NibbleMinFl) return "pad";
    return bus.CrcEn ? "fcs" : "defer";
  endfunction

  // Where the transmitter goes next from s given the current inputs.
  function automatic string model_next(input string s, output bit abort);
    bit hd, cs, col;
    int nib;
    hd    = half_dup();
    cs    = hd && bus.CarrierSense;
    col   = hd && bus.Collision;
    abort = 1'b0;
    nib   = int'(bus.NibCnt) % (1 << IPG_W);
    if (col && sending(s)) return "jam";
    if (s == "defer") begin
      if (bus.ExcessiveDefer && bus.TxStartFrm) begin
        abort = 1'b1;
        return "defer";
      end
      return cs ? "defer" : "ipg";
    end
    if (s == "ipg") begin
      if (!hd || mB2b) return (nib >= int'(bus.IPGT)) ? "idle" : "ipg";
      if (cs && nib < int'(bus.IPGR1)) return "defer";
      return (nib >= int'(bus.IPGR2)) ? "idle" : "ipg";
    end
    if (s == "idle") return bus.TxStartFrm ? "pre" : (cs ? "defer" : "idle");
    if (s == "pre") return bus.NibCntEq15 ? "d0" : "pre";
    if (s == "d0") return "d1";
    if (s == "d1") return (!bus.TxEndFrm && !bus.MaxFrame) ? "d0" : frame_tail();
    if (s == "pad") return bus.NibbleMinFl ? (bus.CrcEn ? "fcs" : "defer") : "pad";
    if (s == "fcs") return bus.NibCntEq7 ? "defer" : "fcs";
    if (s == "jam") begin
      if (!bus.NibCntEq7) return "jam";
      abort = bus.RetryMax;
      return bus.RetryMax ? "defer" : "backoff";
    end
    if (s == "backoff") return bus.RandomEqByteCnt ? "defer" : "backoff";
    return "defer";
  endfunction

  function automatic logic [W-1:0] expect_vec(input string s, input string n, input bit abortReg);
    bit mv;
    mv = (n != s);
    return {s == "idle", s == "defer", s == "ipg", s == "pre", s == "d1", s == "d0",
            s == "pad", s == "fcs", s == "jam", s == "backoff",
            (s == "pre") && bus.NibCntEq15,
            mv && n == "defer", mv && n == "ipg", mv && n == "fcs",
            mv && n == "jam", mv && n == "backoff", abortReg};
  endfunction

  task automatic drive_random();
    logic [8:0] hi;
    logic [6:0] lo;
    bus.TxStartFrm      = chance(30);
    bus.TxEndFrm        = chance(20);
    bus.CarrierSense    = chance(40);
    bus.Collision       = chance(8);
    bus.Pad             = chance(50);
    bus.CrcEn           = chance(60);
    bus.NibCntEq7       = chance(20);
    bus.NibCntEq15      = chance(20);
    bus.NibbleMinFl     = chance(30);
    bus.MaxFrame        = chance(5);
    bus.ExcessiveDefer  = chance(15);
    bus.RetryMax        = chance(50);
    bus.RandomEqByteCnt = chance(30);
    lo = 7'($urandom_range(0, 40));
    hi = chance(30) ? 9'($urandom_range(1, 511)) : 9'd0;
    bus.NibCnt = {hi, lo};
  endtask

  task automatic drive_gaps();
    bus.FullD = 1'($urandom_range(0, 1));
    bus.IPGT  = 7'($urandom_range(0, 30));
    bus.IPGR1 = 7'($urandom_range(0, 20));
    bus.IPGR2 = 7'($urandom_range(0, 30));
  endtask

  always begin
    logic [W-1:0] act, exp_v;
    string nm;
    @(negedge MTxClk);
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = {bus.StateIdle, bus.StateDefer, bus.StateIPG, bus.StatePreamble,
               bus.StateData[1], bus.StateData[0], bus.StatePAD, bus.StateFCS,
               bus.StateJam, bus.StateBackOff, bus.StateSFD, bus.StartDefer,
               bus.StartIPG, bus.StartFCS, bus.StartJam, bus.StartBackoff, bus.TxAbort};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s cyc %0d got %b expected %b", nm, mon_cyc, act, exp_v);
      end
      mon_cyc++;
    end
  end

  initial begin
    string nxt;
    bit    ab;
    drive_random();
    drive_gaps();
    bus.FullD = 1'b1;
    bus.IPGT  = 7'h18;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge MTxClk);
      Reset_n = !(c < 3 || (c >= 1500 && c < 1503) || (c >= 3000 && c < 3004));
      if (c >= 150 && c % 150 == 0) drive_gaps();
      drive_random();
      if (!Reset_n) begin
        mState    = "defer";
        mB2b      = 1'b0;
        mAbortReg = 1'b0;
        nxt       = "defer";
        ab        = 1'b0;
      end else begin
        nxt = model_next(mState, ab);
      end
      exp_q.push_back(expect_vec(mState, nxt, mAbortReg));
      name_q.push_back(Reset_n ? "cycle" : "reset");
      if (Reset_n) begin
        mAbortReg = ab;
        if (mState == "pre") mB2b = 1'b1;
        else if (mState == "idle" || mState == "backoff") mB2b = 1'b0;
        mState = nxt;
      end
    end
    repeat (2) @(negedge MTxClk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
